bp_be_stride_table: RTL

Multi-entry, parametrised stride detector for the BE pre-issue stage. It watches integer and FP loads as they leave the issue queue and tracks per-PC address strides in a small fully-associative table. It reports stride discovery (start) and stride confirmation events to the loop-inference logic through a one-deep valid/yumi output register. It replaces the single-PC stride detector and adds multiple tracked PCs, confidence hysteresis, event backpressure and flush.

---
 rtl/bp_be_pkg.sv | 21 ++
 rtl/bp_be_stride_entry.sv | 133 +++++++++++++
 rtl/bp_be_stride_table.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared definitions for the BE pre-issue stride detector.
//   bp_params_e / bp_vaddr_width : processor configuration and derived vaddr width
//   bp_be_stride_state_e         : per-entry training state
//   rv64_*_op                    : load opcodes recognised by the detector
package bp_be_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  typedef enum logic [1:0] {e_init, e_train, e_steady} bp_be_stride_state_e;

  localparam logic [6:0] rv64_load_op    = 7'b0000011;
  localparam logic [6:0] rv64_fp_load_op = 7'b0000111;

endpackage

// File: rtl/bp_be_stride_entry.sv
// One stride table entry: registers, training FSM and PC hit compare.
//   clk_i, reset_n_i, flush_i : clock, sync active-low reset, table flush
//   pc_i, addr_i              : PC and effective address of the current load
//   load_i                    : load hits this entry (update it)
//   alloc_i                   : allocate this entry for pc_i
//   v_o, hit_o                : entry valid, entry matches pc_i
//   ev_v_o, ev_confirm_o      : event produced by this load (start/confirm)
//   stride_o                  : the entry's new stride for the event
module bp_be_stride_entry
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p  = 39,
  parameter int stride_width_p = 16,
  parameter int conf_width_p   = 2,
  parameter int conf_thresh_p  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  addr_i,
  input  logic                      load_i,
  input  logic                      alloc_i,
  output logic                      v_o,
  output logic                      hit_o,
  output logic                      ev_v_o,
  output logic                      ev_confirm_o,
  output logic [stride_width_p-1:0] stride_o
);

  logic                      v_reg;
  logic [vaddr_width_p-1:0]  pc_reg, last_addr_reg;
  logic [stride_width_p-1:0] stride_reg, stride_next;
  logic [conf_width_p-1:0]   conf_reg, conf_next;
  bp_be_stride_state_e       state_reg, state_next;

  logic [vaddr_width_p-1:0]        delta, delta_hi;
  logic signed [vaddr_width_p-1:0] delta_s;
  logic delta_valid, stride_match, ev_v, ev_confirm;

  assign delta   = addr_i - last_addr_reg;
  assign delta_s = delta;
  // Delta fits the stride field iff every bit from stride_width_p-1 upward is a
  // copy of the sign, i.e. the arithmetic shift leaves all zeros or all ones.
  assign delta_hi     = delta_s >>> (stride_width_p - 1);
  assign delta_valid  = (delta != '0) && ((delta_hi == '0) || (delta_hi == '1));
  // Stored strides are always valid, so low-bit equality on a valid delta is full equality.
  assign stride_match = delta_valid && (delta[stride_width_p-1:0] == stride_reg);

  always_comb begin
    state_next  = state_reg;
    conf_next   = conf_reg;
    stride_next = stride_reg;
    ev_v        = 1'b0;
    ev_confirm  = 1'b0;
    case (state_reg)
      e_init: begin
        if (delta_valid) begin
          stride_next = delta[stride_width_p-1:0];
          conf_next   = '0;
          state_next  = e_train;
          ev_v        = 1'b1;
        end
      end
      e_train: begin
        if (stride_match) begin
          conf_next = conf_reg + conf_width_p'(1);
          if (conf_next == conf_width_p'(conf_thresh_p)) begin
            state_next = e_steady;
            ev_v       = 1'b1;
            ev_confirm = 1'b1;
          end
        end else if (delta_valid) begin
          stride_next = delta[stride_width_p-1:0];
          conf_next   = '0;
          ev_v        = 1'b1;
        end else begin
          conf_next  = '0;
          state_next = e_init;
        end
      end
      e_steady: begin
        if (stride_match) begin
          if (conf_reg != '1) conf_next = conf_reg + conf_width_p'(1);
        end else if (conf_reg <= conf_width_p'(1)) begin
          // Hysteresis exhausted: retrain on the new delta if it is usable.
          conf_next = '0;
          if (delta_valid) begin
            stride_next = delta[stride_width_p-1:0];
            state_next  = e_train;
            ev_v        = 1'b1;
          end else begin
            state_next = e_init;
          end
        end else begin
          conf_next = conf_reg - conf_width_p'(1);
        end
      end
      default: state_next = e_init;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_reg         <= 1'b0;
      pc_reg        <= '0;
      last_addr_reg <= '0;
      stride_reg    <= '0;
      conf_reg      <= '0;
      state_reg     <= e_init;
    end else if (flush_i) begin
      v_reg <= 1'b0;
    end else if (alloc_i) begin
      v_reg         <= 1'b1;
      pc_reg        <= pc_i;
      last_addr_reg <= addr_i;
      conf_reg      <= '0;
      state_reg     <= e_init;
    end else if (load_i) begin
      last_addr_reg <= addr_i;
      stride_reg    <= stride_next;
      conf_reg      <= conf_next;
      state_reg     <= state_next;
    end
  end

  assign v_o          = v_reg;
  assign hit_o        = v_reg && (pc_reg == pc_i);
  assign ev_v_o       = load_i && ev_v;
  assign ev_confirm_o = ev_confirm;
  assign stride_o     = stride_next;

endmodule

// File: rtl/bp_be_stride_table.sv
// Multi-entry per-PC stride detector for the BE pre-issue stage.
//   clk_i, reset_n_i, flush_i        : clock, sync active-low reset, flush
//   instr_v_i, instr_i, pc_i, rs1_i  : pre-issue instruction and its rs1 data
//   v_o, confirm_o, pc_o, stride_o   : registered event (start / confirm)
//   yumi_i                           : consumer takes the event
//   drop_cnt_o                       : saturating count of dropped events
module bp_be_stride_table
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int entries_p      = 4,
  parameter int stride_width_p = 16,
  parameter int conf_width_p   = 2,
  parameter int conf_thresh_p  = 2,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      instr_v_i,
  input  logic [31:0]               instr_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [63:0]               rs1_i,
  output logic                      v_o,
  output logic                      confirm_o,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [stride_width_p-1:0] stride_o,
  input  logic                      yumi_i,
  output logic [7:0]                drop_cnt_o
);

  // At least one bit so a single-entry table still has a (constant) victim pointer.
  localparam int ptr_width_lp = (entries_p > 1) ? $clog2(entries_p) : 1;

  logic                     load_v, miss, any_hit, free_found;
  logic [vaddr_width_p-1:0] addr;
  logic [ptr_width_lp-1:0]  victim_ptr_reg, free_idx, alloc_idx;
  logic [entries_p-1:0]     entry_v, entry_hit, entry_ev_v, entry_ev_confirm, alloc_onehot;
  logic [stride_width_p-1:0] entry_stride [entries_p];
  logic                      ev_v, ev_confirm;
  logic [stride_width_p-1:0] ev_stride;
  logic                      unused_bits;

  assign unused_bits = ^{instr_i[19:7], rs1_i[63:vaddr_width_p]};

  // A flushed cycle's load is discarded entirely.
  assign load_v = instr_v_i && !flush_i
               && ((instr_i[6:0] == rv64_load_op) || (instr_i[6:0] == rv64_fp_load_op));
  assign addr   = rs1_i[vaddr_width_p-1:0]
                + {{(vaddr_width_p-12){instr_i[31]}}, instr_i[31:20]};

  assign any_hit = |entry_hit;
  assign miss    = load_v && !any_hit;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Descending scan so the lowest invalid index wins.
    for (int i = entries_p - 1; i >= 0; i--) begin
      if (!entry_v[i]) begin
        free_found = 1'b1;
        free_idx   = ptr_width_lp'(i);
      end
    end
  end

  assign alloc_idx = free_found ? free_idx : victim_ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < entries_p; gi++) begin : g_entry
      assign alloc_onehot[gi] = miss && (alloc_idx == ptr_width_lp'(gi));
      bp_be_stride_entry #(
        .vaddr_width_p (vaddr_width_p),
        .stride_width_p(stride_width_p),
        .conf_width_p  (conf_width_p),
        .conf_thresh_p (conf_thresh_p)
      ) u_entry (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .flush_i     (flush_i),
        .pc_i        (pc_i),
        .addr_i      (addr),
        .load_i      (load_v && entry_hit[gi]),
        .alloc_i     (alloc_onehot[gi]),
        .v_o         (entry_v[gi]),
        .hit_o       (entry_hit[gi]),
        .ev_v_o      (entry_ev_v[gi]),
        .ev_confirm_o(entry_ev_confirm[gi]),
        .stride_o    (entry_stride[gi])
      );
    end
  endgenerate

  // At most one entry hits, so OR-combining the masked entry events is a mux.
  always_comb begin
    ev_v       = 1'b0;
    ev_confirm = 1'b0;
    ev_stride  = '0;
    for (int i = 0; i < entries_p; i++) begin
      ev_v       = ev_v | entry_ev_v[i];
      ev_confirm = ev_confirm | (entry_ev_v[i] & entry_ev_confirm[i]);
      ev_stride  = ev_stride | (entry_stride[i] & {stride_width_p{entry_ev_v[i]}});
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || flush_i) begin
      victim_ptr_reg <= '0;
    end else if (miss && !free_found) begin
      victim_ptr_reg <= (victim_ptr_reg == ptr_width_lp'(entries_p - 1))
                        ? '0 : victim_ptr_reg + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_o        <= 1'b0;
      confirm_o  <= 1'b0;
      pc_o       <= '0;
      stride_o   <= '0;
      drop_cnt_o <= '0;
    end else if (flush_i) begin
      v_o <= 1'b0;
    end else if (ev_v) begin
      if (!v_o || yumi_i) begin
        v_o       <= 1'b1;
        confirm_o <= ev_confirm;
        pc_o      <= pc_i;
        stride_o  <= ev_stride;
      end else if (drop_cnt_o != 8'hFF) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end else if (yumi_i) begin
      v_o <= 1'b0;
    end
  end

endmodule
